// File: rtl/axi_lite_cmd_master.sv
// -----------------------------------------------------------------------------
// axi_lite_cmd_master
//
// AXI4-Lite initiator. It accepts one single-beat register command at a time
// on a valid/ready command port, runs the matching AXI4-Lite write or read
// transaction, and returns one response per command on a valid/ready
// response port. It is intended to drive the bridge register slave
// (DBG, PWM, clock-divider, AUX) from on-chip logic such as a sequencer.
//
// Optional feature macro: AXI_MASTER_CMP_EN
//   When defined, each read is compared against an expected value latched
//   with the command. The result appears on rsp_mismatch, and a saturating
//   16-bit mismatch_count is kept. When undefined, those ports do not exist.
//
// Ports
//   M_AXI_ACLK, M_AXI_ARESETN   clock, asynchronous active-low reset
//   cmd_*                       command in (valid/ready): write flag,
//                               address, write data, write strobes
//   rsp_*                       response out (valid/ready): read data
//                               (0 for writes), captured BRESP/RRESP
//   busy                        high whenever the FSM is not IDLE
//   M_AXI_AW*/W*/B*/AR*/R*      AXI4-Lite master channels
//   cmd_expect, rsp_mismatch,
//   mismatch_count              compare feature (AXI_MASTER_CMP_EN only)
//
// Every output comes straight from a flop and resets to 0.
// -----------------------------------------------------------------------------
module axi_lite_cmd_master #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      M_AXI_ACLK,
  input  logic                      M_AXI_ARESETN,
  // Command port
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
`ifdef AXI_MASTER_CMP_EN
  input  logic [DATA_WIDTH-1:0]     cmd_expect,
  output logic                      rsp_mismatch,
  output logic [15:0]               mismatch_count,
`endif
  // Response port
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      busy,
  // AXI4-Lite write address channel
  output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  // AXI4-Lite write data channel
  output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  // AXI4-Lite write response channel
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  // AXI4-Lite read address channel
  output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  // AXI4-Lite read data channel
  input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_e;

  state_e                    state_q;
  logic                      cmd_ready_q;
  logic                      rsp_valid_q;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q;
  logic [1:0]                rsp_resp_q;
  logic                      busy_q;
  logic [ADDR_WIDTH-1:0]     awaddr_q;
  logic                      awvalid_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH/8-1:0]   wstrb_q;
  logic                      wvalid_q;
  logic                      bready_q;
  logic [ADDR_WIDTH-1:0]     araddr_q;
  logic                      arvalid_q;
  logic                      rready_q;
`ifdef AXI_MASTER_CMP_EN
  logic [DATA_WIDTH-1:0]     expect_q;
  logic                      mismatch_q;
  logic [15:0]               mismatch_count_q;
  logic                      rd_mismatch;
`endif

  // A write channel is finished once its VALID has already dropped, or when
  // its handshake happens this cycle. AW and W may finish in either order or
  // together; WR_RESP is entered only when both are finished.
  logic aw_fin;
  logic w_fin;
  assign aw_fin = !awvalid_q || M_AXI_AWREADY;
  assign w_fin  = !wvalid_q  || M_AXI_WREADY;

`ifdef AXI_MASTER_CMP_EN
  assign rd_mismatch = (M_AXI_RDATA != expect_q);
`endif

  // NOTE: all state and outputs use non-blocking assignments, so every
  // branch below reads the values from before this clock edge, and a later
  // assignment in the same branch simply overrides an earlier one.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      // NOTE: the reset is asynchronous, so every VALID/READY output drops
      // the moment reset asserts, not at the next clock edge.
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      busy_q      <= 1'b0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
`ifdef AXI_MASTER_CMP_EN
      expect_q         <= '0;
      mismatch_q       <= 1'b0;
      mismatch_count_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // cmd_ready rises on the first clock after reset and stays up
          // until a command is taken.
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
`ifdef AXI_MASTER_CMP_EN
            expect_q    <= cmd_expect;
`endif
            if (cmd_write) begin
              awaddr_q  <= cmd_addr;
              awvalid_q <= 1'b1;
              wdata_q   <= cmd_wdata;
              wstrb_q   <= cmd_wstrb;
              wvalid_q  <= 1'b1;
              state_q   <= WR_ADDR_DATA;
            end else begin
              araddr_q  <= cmd_addr;
              arvalid_q <= 1'b1;
              state_q   <= RD_ADDR;
            end
          end
        end

        WR_ADDR_DATA: begin
          // Each channel clears its VALID and zeroes its payload independently.
          if (awvalid_q && M_AXI_AWREADY) begin
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
          end
          if (wvalid_q && M_AXI_WREADY) begin
            wvalid_q <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
          end
          if (aw_fin && w_fin) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end

        WR_RESP: begin
          // BREADY is already high here, so BVALID alone is the handshake.
          if (M_AXI_BVALID) begin
            bready_q    <= 1'b0;
            rsp_resp_q  <= M_AXI_BRESP;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
`ifdef AXI_MASTER_CMP_EN
            mismatch_q  <= 1'b0;
`endif
            state_q     <= RSP;
          end
        end

        RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (M_AXI_RVALID) begin
            rready_q    <= 1'b0;
            rsp_rdata_q <= M_AXI_RDATA;
            rsp_resp_q  <= M_AXI_RRESP;
            rsp_valid_q <= 1'b1;
`ifdef AXI_MASTER_CMP_EN
            mismatch_q  <= rd_mismatch;
            if (rd_mismatch && (mismatch_count_q != 16'hFFFF)) begin
              mismatch_count_q <= mismatch_count_q + 16'd1;
            end
`endif
            state_q     <= RSP;
          end
        end

        RSP: begin
          // Response payload is held until consumed; cmd_ready returns the
          // cycle after the response handshake.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign busy          = busy_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
`ifdef AXI_MASTER_CMP_EN
  assign rsp_mismatch   = mismatch_q;
  assign mismatch_count = mismatch_count_q;
`endif

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_cmd_master
//
// Self-checking bench for axi_lite_cmd_master. A behavioural AXI4-Lite slave
// with per-channel wait-state settings and a small register memory answers
// the DUT. Expected responses are pushed to a scoreboard queue when each
// command is issued and popped when the DUT completes a response handshake.
// A table of commands covers the bulk traffic; hand-written sequences cover
// latency, stalls, reset mid-transaction and the optional compare feature.
// -----------------------------------------------------------------------------
module tb_axi_lite_cmd_master;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // DUT ports
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          busy;
  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic          awready = 1'b0;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wvalid;
  logic          wready  = 1'b0;
  logic [1:0]    bresp   = '0;
  logic          bvalid  = 1'b0;
  logic          bready;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [DW-1:0] rdata   = '0;
  logic [1:0]    rresp   = '0;
  logic          rvalid  = 1'b0;
  logic          rready;
`ifdef AXI_MASTER_CMP_EN
  logic [DW-1:0] cmd_expect = '0;
  logic          rsp_mismatch;
  logic [15:0]   mismatch_count;
`endif

  axi_lite_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
`ifdef AXI_MASTER_CMP_EN
    .cmd_expect    (cmd_expect),
    .rsp_mismatch  (rsp_mismatch),
    .mismatch_count(mismatch_count),
`endif
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .busy          (busy),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_BRESP   (bresp),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready),
    .M_AXI_ARADDR  (araddr),
    .M_AXI_ARVALID (arvalid),
    .M_AXI_ARREADY (arready),
    .M_AXI_RDATA   (rdata),
    .M_AXI_RRESP   (rresp),
    .M_AXI_RVALID  (rvalid),
    .M_AXI_RREADY  (rready)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    logic          mism;
  } exp_t;
  exp_t sb_q[$];

  // Slave configuration (wait states before READY / response VALID)
  int         aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
  logic [1:0] bresp_cfg = '0, rresp_cfg = '0;
  logic [DW-1:0] mem [0:127];

  // Slave state
  bit            got_aw, got_w, b_pend, r_pend;
  int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [AW-1:0] s_wa, s_ra;
  logic [DW-1:0] s_wd;
  logic [SW-1:0] s_ws;

  // DUT outputs as seen during the previous cycle
  logic          p_awv, p_wv, p_bready, p_arv, p_rready, p_rspv;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [DW-1:0] p_wdata, p_rdata;
  logic [SW-1:0] p_wstrb;
  logic [1:0]    p_resp;
  logic          p_mism;

  // Monitors
  int cyc = 0;
  int awv_cyc, wv_cyc, aw_only_cyc, bready_cyc, arv_cyc, rready_cyc, rspv_cyc;
  int aw_hs, w_hs, b_hs, rsp_cnt;
  int rsp_rise_edge = 0;
  int acc_edge = 0;
  int bad_ready = 0;
  int stab_err = 0;

  task automatic clear_mon();
    awv_cyc = 0; wv_cyc = 0; aw_only_cyc = 0; bready_cyc = 0;
    arv_cyc = 0; rready_cyc = 0; rspv_cyc = 0;
    aw_hs = 0; w_hs = 0; b_hs = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Slave model + response monitor, evaluated 1 time unit after each edge.
  // Handshakes are judged from the values that were present before the edge.
  // ---------------------------------------------------------------------------
  initial begin : slave_model
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        p_awv = 0; p_wv = 0; p_bready = 0; p_arv = 0; p_rready = 0; p_rspv = 0;
      end else begin
        // Stability: an un-handshaken VALID must stay high with stable payload
        if (p_awv && !awready && (!awvalid || awaddr != p_awaddr)) stab_err++;
        if (p_wv && !wready && (!wvalid || wdata != p_wdata || wstrb != p_wstrb)) stab_err++;
        if (p_arv && !arready && (!arvalid || araddr != p_araddr)) stab_err++;
        if (p_rspv && !rsp_ready && (!rsp_valid || rsp_rdata != p_rdata || rsp_resp != p_resp)) stab_err++;
        if (!awvalid && awaddr != '0) stab_err++;
        if (!wvalid && (wdata != '0 || wstrb != '0)) stab_err++;
        if (!arvalid && araddr != '0) stab_err++;
        if (cmd_ready && (busy || rsp_valid)) bad_ready++;

        // Handshakes that completed at this edge
        if (bvalid && p_bready) begin
          for (int i = 0; i < SW; i++) begin
            if (s_ws[i]) mem[s_wa[8:2]][8*i +: 8] = s_wd[8*i +: 8];
          end
          bvalid = 0; b_pend = 0; got_aw = 0; got_w = 0; b_hs++;
        end
        if (awready && p_awv) begin got_aw = 1; s_wa = p_awaddr; aw_hs++; end
        if (wready && p_wv) begin got_w = 1; s_wd = p_wdata; s_ws = p_wstrb; w_hs++; end
        if (got_aw && got_w && !b_pend) begin b_pend = 1; b_cnt = 0; end
        if (rvalid && p_rready) begin rvalid = 0; r_pend = 0; end
        if (arready && p_arv) begin r_pend = 1; r_cnt = 0; s_ra = p_araddr; end
        if (p_rspv && rsp_ready) begin
          rsp_cnt++;
          if (sb_q.size() == 0) begin
            check("rsp_unexpected", 64'd1, 64'd0);
          end else begin
            e = sb_q.pop_front();
            check("rsp_rdata", p_rdata, e.rdata);
            check("rsp_resp", p_resp, e.resp);
`ifdef AXI_MASTER_CMP_EN
            check("rsp_mismatch", p_mism, e.mism);
`endif
          end
        end
        if (rsp_valid && !p_rspv) rsp_rise_edge = cyc;

        // Slave outputs for the coming cycle
        if (awvalid) begin
          if (aw_cnt >= aw_lat) awready = 1; else begin awready = 0; aw_cnt++; end
        end else begin awready = 0; aw_cnt = 0; end
        if (wvalid) begin
          if (w_cnt >= w_lat) wready = 1; else begin wready = 0; w_cnt++; end
        end else begin wready = 0; w_cnt = 0; end
        if (arvalid) begin
          if (ar_cnt >= ar_lat) arready = 1; else begin arready = 0; ar_cnt++; end
        end else begin arready = 0; ar_cnt = 0; end
        if (b_pend && !bvalid) begin
          if (b_cnt >= b_lat) begin bvalid = 1; bresp = bresp_cfg; end else b_cnt++;
        end
        if (r_pend && !rvalid) begin
          if (r_cnt >= r_lat) begin
            rvalid = 1; rdata = mem[s_ra[8:2]]; rresp = rresp_cfg;
          end else r_cnt++;
        end

        // Activity counters for the cycle now starting
        if (awvalid) awv_cyc++;
        if (wvalid) wv_cyc++;
        if (awvalid && !wvalid) aw_only_cyc++;
        if (bready) bready_cyc++;
        if (arvalid) arv_cyc++;
        if (rready) rready_cyc++;
        if (rsp_valid) rspv_cyc++;

        p_awv = awvalid; p_awaddr = awaddr;
        p_wv = wvalid; p_wdata = wdata; p_wstrb = wstrb;
        p_bready = bready; p_arv = arvalid; p_araddr = araddr; p_rready = rready;
        p_rspv = rsp_valid; p_rdata = rsp_rdata; p_resp = rsp_resp;
`ifdef AXI_MASTER_CMP_EN
        p_mism = rsp_mismatch;
`else
        p_mism = 1'b0;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Command driver: pushes the expectation, then waits (bounded) for accept.
  // The slave response code is applied once the previous command is finished.
  // ---------------------------------------------------------------------------
  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input logic [1:0] resp_cfg,
                          input logic [DW-1:0] exp_in, input logic [DW-1:0] exp_rd,
                          input logic [1:0] exp_rsp, input logic exp_mism);
    exp_t e;
    int t;
    e.rdata = exp_rd; e.resp = exp_rsp; e.mism = exp_mism;
    sb_q.push_back(e);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
`ifdef AXI_MASTER_CMP_EN
    cmd_expect = exp_in;
`endif
    t = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      t++;
      if (t > 200) begin
        check("cmd_accept_timeout", 64'd1, 64'd0);
        break;
      end
    end
    bresp_cfg = resp_cfg; rresp_cfg = resp_cfg;
    @(posedge clk);
    #2;
    acc_edge  = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while ((sb_q.size() != 0 || busy) && t < 500) begin
      @(posedge clk);
      #2;
      t++;
    end
    if (t >= 500) check({tag, "_timeout"}, 64'd1, 64'd0);
    @(posedge clk);
    #2;
  endtask

  function automatic logic any_out();
    return cmd_ready | rsp_valid | (|rsp_rdata) | (|rsp_resp) | busy | (|awaddr) | awvalid |
           (|wdata) | (|wstrb) | wvalid | bready | (|araddr) | arvalid | rready;
  endfunction

  // ---------------------------------------------------------------------------
  // Command table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    resp_cfg;
    logic [DW-1:0] exp_rdata;
    logic [1:0]    exp_resp;
  } vec_t;
  localparam int NV = 25;
  vec_t vecs [NV];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    for (int i = 0; i < 128; i++) mem[i] = '0;

    // Ten writes of 0xDEADBEEF to 0x00..0x24, then ten reads back in order,
    // followed by strobe, error-response and EXOKAY cases.
    for (int i = 0; i < 10; i++) begin
      vecs[i]      = '{1'b1, AW'(4 * i), 32'hDEADBEEF, 4'hF, 2'd0, 32'h0, 2'd0};
      vecs[i + 10] = '{1'b0, AW'(4 * i), 32'h0, 4'h0, 2'd0, 32'hDEADBEEF, 2'd0};
    end
    vecs[20] = '{1'b1, 9'h040, 32'hFFFFFFFF, 4'hF, 2'd0, 32'h0, 2'd0};
    vecs[21] = '{1'b1, 9'h040, 32'h12345678, 4'h5, 2'd0, 32'h0, 2'd0};
    vecs[22] = '{1'b0, 9'h040, 32'h0, 4'h0, 2'd0, 32'hFF34FF78, 2'd0};
    vecs[23] = '{1'b1, 9'h080, 32'hA5A5A5A5, 4'hF, 2'd3, 32'h0, 2'd3};
    vecs[24] = '{1'b0, 9'h044, 32'h0, 4'h0, 2'd1, 32'h0, 2'd1};

    // ---- Reset behaviour ----
    #1 rst_n = 1'b0;
    #2;
    check("reset_outputs_zero", any_out(), 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("cmd_ready_before_first_clock", cmd_ready, 1'b0);
    @(posedge clk);
    #2;
    check("cmd_ready_after_first_clock", cmd_ready, 1'b1);
    check("busy_idle", busy, 1'b0);

    // ---- Write 0x0 <- 0xDEADBEEF, always-ready slave ----
    clear_mon();
    base = rsp_cnt;
    send_cmd(1'b1, 9'h000, 32'hDEADBEEF, 4'hF, 2'd0, 32'h0, 32'h0, 2'd0, 1'b0);
    wait_done("wr_fast");
    check("wr_fast_awvalid_cycles", awv_cyc, 1);
    check("wr_fast_wvalid_cycles", wv_cyc, 1);
    check("wr_fast_bready_cycles", bready_cyc, 1);
    // rsp_valid set at edge N+2, i.e. high during cycle N+3
    check("wr_fast_rsp_latency", rsp_rise_edge - acc_edge, 2);
    check("wr_fast_rsp_valid_cycles", rspv_cyc, 1);
    check("wr_fast_rsp_count", rsp_cnt - base, 1);

    // ---- Write 0x24, W ready two cycles before AW ----
    clear_mon();
    base = rsp_cnt;
    aw_lat = 2;
    send_cmd(1'b1, 9'h024, 32'h0BADF00D, 4'hF, 2'd0, 32'h0, 32'h0, 2'd0, 1'b0);
    wait_done("wr_split");
    aw_lat = 0;
    check("wr_split_awvalid_cycles", awv_cyc, 3);
    check("wr_split_wvalid_cycles", wv_cyc, 1);
    check("wr_split_aw_only_cycles", aw_only_cyc, 2);
    check("wr_split_bready_cycles", bready_cyc, 1);
    check("wr_split_handshakes", {aw_hs[7:0], w_hs[7:0], b_hs[7:0]}, 24'h010101);
    check("wr_split_rsp_count", rsp_cnt - base, 1);

    // ---- Read 0x4, ARREADY after 1 wait, RVALID after 5 waits, SLVERR,
    //      response consumer stalls for 3 cycles ----
    mem[1] = 32'hDEADBEEF;
    clear_mon();
    ar_lat = 1; r_lat = 5;
    rsp_ready = 1'b0;
    send_cmd(1'b0, 9'h004, 32'h0, 4'h0, 2'd2, 32'hDEADBEEF, 32'hDEADBEEF, 2'd2, 1'b0);
    begin : wait_rsp
      int t;
      t = 0;
      while (!rsp_valid && t < 100) begin
        @(posedge clk);
        #2;
        t++;
      end
      check("rd_slow_rsp_seen", rsp_valid, 1'b1);
    end
    repeat (3) @(posedge clk);
    #2;
    rsp_ready = 1'b1;
    wait_done("rd_slow");
    ar_lat = 0; r_lat = 0;
    check("rd_slow_arvalid_cycles", arv_cyc, 2);
    check("rd_slow_rready_cycles", rready_cyc, 6);
    check("rd_slow_rsp_valid_cycles", rspv_cyc, 4);

    // ---- Table: back-to-back traffic ----
    base = rsp_cnt;
    for (int i = 0; i < NV; i++) begin
      send_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].resp_cfg,
               vecs[i].exp_rdata, vecs[i].exp_rdata, vecs[i].exp_resp, 1'b0);
    end
    wait_done("table");
    check("table_rsp_count", rsp_cnt - base, NV);

    // ---- Reset while WR_RESP waits for BVALID ----
    b_lat = 40;
    base = rsp_cnt;
    send_cmd(1'b1, 9'h028, 32'h55AA55AA, 4'hF, 2'd0, 32'h0, 32'h0, 2'd0, 1'b0);
    begin : wait_bready
      int t;
      t = 0;
      while (!bready && t < 20) begin
        @(posedge clk);
        #2;
        t++;
      end
      check("rst_mid_bready_reached", bready, 1'b1);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_outputs_zero_async", any_out(), 1'b0);
    sb_q.delete();
    repeat (3) @(posedge clk);
    #2;
    check("rst_mid_outputs_zero_held", any_out(), 1'b0);
    b_lat = 0;
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    check("rst_mid_no_response", rsp_cnt - base, 0);
    check("rst_mid_cmd_ready", cmd_ready, 1'b1);
    send_cmd(1'b0, 9'h00C, 32'h0, 4'h0, 2'd0, 32'hDEADBEEF, 32'hDEADBEEF, 2'd0, 1'b0);
    wait_done("rst_mid_read");
    check("rst_mid_read_count", rsp_cnt - base, 1);

`ifdef AXI_MASTER_CMP_EN
    // ---- Compare feature ----
    mem[1] = 32'h12345678;
    send_cmd(1'b0, 9'h004, 32'h0, 4'h0, 2'd0, 32'hDEADBEEF, 32'h12345678, 2'd0, 1'b1);
    wait_done("cmp_miss");
    check("cmp_count_after_miss", mismatch_count, 16'd1);
    send_cmd(1'b0, 9'h004, 32'h0, 4'h0, 2'd0, 32'h12345678, 32'h12345678, 2'd0, 1'b0);
    wait_done("cmp_hit");
    check("cmp_count_after_hit", mismatch_count, 16'd1);
`endif

    check("cmd_ready_overlap", bad_ready, 0);
    check("channel_stability", stab_err, 0);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/axi_lite_cmd_master.md
# axi_lite_cmd_master

- AXI4-Lite initiator that turns single-beat register commands into AXI4-Lite write and read transactions, and returns one response per command.
- Drives the register slave port of the neuromorphic ASIC bridge top (DBG, PWM, clock-divider and AUX registers) from on-chip logic such as a sequencer or UART bridge, in place of an external processor.
- Handles one transaction at a time; the command and response interfaces are valid/ready.

## Interface
Parameters:
- ADDR_WIDTH, 9: AXI address width.
- DATA_WIDTH, 32: AXI data width. WSTRB width is DATA_WIDTH/8.

Ports:
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESETN  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  captured BRESP or RRESP.
- busy  out  1  high whenever state is not IDLE.
- M_AXI_AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master signals. Address buses are ADDR_WIDTH wide, data buses DATA_WIDTH wide, and WSTRB DATA_WIDTH/8 wide.

## Operation
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - cmd_ready = 1.
  - On a cmd handshake, latch addr, wdata, wstrb and write.
  - Go to WR_ADDR_DATA if write, otherwise RD_ADDR.
- WR_ADDR_DATA:
  - AWVALID and WVALID assert together.
  - Each deasserts independently the cycle after its own handshake.
  - AW and W handshakes in the same cycle are legal.
  - When both are done, go to WR_RESP.
- WR_RESP:
  - BREADY = 1.
  - On BVALID, capture BRESP, set rsp_rdata = 0, go to RSP.
- RD_ADDR:
  - ARVALID = 1 until the ARREADY handshake, then go to RD_DATA.
- RD_DATA:
  - RREADY = 1.
  - On RVALID, capture RDATA and RRESP, go to RSP.
- RSP:
  - rsp_valid = 1, with data held stable.
  - On rsp_ready, return to IDLE.
- VALID signals never drop before their handshake. Address, data and strobe outputs stay stable while their VALID is high.
- BREADY is low outside WR_RESP and RREADY is low outside RD_DATA.
- AWADDR/ARADDR/WDATA/WSTRB drive the latched values while the matching VALID is high. They are 0 otherwise.
- A non-OKAY response is passed through unchanged and does not stop operation.

## Timing
- All outputs are registered.
- Reset value of every output is 0: cmd_ready, rsp_*, busy and every M_AXI_* output.
- cmd_ready goes to 1 on the first clock after reset deasserts.
- Command accepted at edge N: AWVALID/WVALID or ARVALID are high from cycle N+1.
- Write with an always-ready slave: AW/W handshake at N+1, BREADY high from N+2.
- rsp_valid rises the cycle after the B or R handshake.
  - Best-case write (BVALID at N+2): rsp_valid at N+3.
  - Best-case read (RVALID at N+2): rsp_valid at N+3.
- cmd_ready is low from N+1 until the cycle after the rsp handshake. Back-to-back command throughput is therefore one command per 4 cycles minimum.
- A held rsp_ready gives rsp_valid exactly one cycle.
- Reset asserted mid-transaction:
  - All VALID/READY outputs drop immediately (asynchronously).
  - The state returns to IDLE.
  - The in-flight response is discarded.

## Configuration
- AXI_MASTER_CMP_EN defined:
  - Adds input cmd_expect (DATA_WIDTH) and outputs rsp_mismatch (1) and mismatch_count (16).
  - cmd_expect is latched with the command.
  - On read completion, rsp_mismatch = (RDATA != expect) and is valid with rsp_valid.
  - mismatch_count increments on each mismatching read and saturates at 0xFFFF. Reset value is 0.
  - Writes always give rsp_mismatch = 0.
- AXI_MASTER_CMP_EN undefined:
  - The three compare ports and their logic do not exist.
  - All other behaviour is identical.

## Test plan
- Write 0x0 <- 0xDEADBEEF, wstrb 0xF, slave ready immediately:
  - AWVALID/WVALID high one cycle, BREADY high one cycle.
  - rsp_valid at N+3 with rsp_resp 0, rsp_rdata 0.
- Write to 0x24, slave asserts WREADY 2 cycles before AWREADY:
  - WVALID drops after the W handshake while AWVALID stays high.
  - Exactly one B wait follows, and one response.
- Read 0x4, slave returns 0xDEADBEEF after 5 wait cycles with RRESP 2 (SLVERR):
  - ARVALID held until ARREADY.
  - rsp_rdata 0xDEADBEEF, rsp_resp 2.
- Ten back-to-back writes to 0x0..0x24 step 4, then ten reads of the same addresses:
  - Every read returns 0xDEADBEEF in order.
  - cmd_ready never high while busy.
- Reset pulse while WR_RESP waits for BVALID:
  - All outputs 0 during reset, no response produced.
  - A following read of 0xC completes normally.
- With AXI_MASTER_CMP_EN: read 0x4 returning 0x12345678 with cmd_expect 0xDEADBEEF:
  - rsp_mismatch 1, mismatch_count 1.
  - Matching read gives 0 with count unchanged.
